adc_frame_transmitter: RTL and testbench
========================================

# adc_frame_transmitter

Serial ADC frame source that drives the far end of the ADC serial link: generates the data-ready strobe, the bit clock and two serial data lanes carrying an 8-channel × 32-bit TDM frame. It is used as an on-board ADC emulator for bench and self-test, driving `adc_serial_interface` inputs directly. Channel words come from a CPU-writable register file, snapshotted at each frame start.

## Interface
- `CLK_DIV`, default 4: system clocks per `adc_clock` half-period; legal range is 2 or more.
- `DRDY_WIDTH`, default 4: system clocks that `adc_data_ready` is held high per frame; legal range is 1 or more.
- `FRAME_GAP`, default 64: idle system clocks after the last bit before the next frame; legal range is 1 or more.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: free-run frames while high.
- `ch_wr_en` in 1: register-file write strobe.
- `ch_wr_addr` in 3: channel index, 0 = ch1 … 7 = ch8.
- `ch_wr_data` in 32: channel word.
- `pattern_sel` in 1: selects the pattern source. Present only with `ADC_TX_PATTERN_EN`.
- `adc_data_ready` out 1: frame-start strobe.
- `adc_clock` out 1: serial bit clock; idles low.
- `adc_data_0` out 1: lane 0, MSB first.
- `adc_data_1` out 1: lane 1, the bitwise inverse of lane 0 during SHIFT.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when the last bit completes.

## Operation
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
  - Register file: channel n holds 32'h0000000n (ch1 = 1 … ch8 = 8).
  - Shadow words are 0.
  - Frame counter is 0.
- FSM states: IDLE, DRDY, SHIFT, GAP.
  - IDLE → DRDY when `enable` = 1.
  - DRDY → SHIFT after `DRDY_WIDTH` cycles.
  - SHIFT → GAP after bit 255 completes.
  - GAP → DRDY after `FRAME_GAP` cycles if `enable` = 1, otherwise GAP → IDLE.
- Snapshot:
  - On entry to DRDY, all 8 register words are copied to the shadow words.
  - A write in the same cycle as the snapshot does not appear in the snapshot; it lands in the next frame.
- Writes: accepted in any state, never stalled, with no effect on the frame in flight.
- Bit order:
  - Bit k (0..255) carries bit 31−(k mod 32) of shadow word k/32, so ch1 is sent first, MSB first.
  - `adc_data_1` is the inverse of `adc_data_0` for every bit.
- Bit period (2×`CLK_DIV` cycles):
  - In the first cycle, `adc_clock` rises and the data lanes update together with it.
  - `adc_clock` falls after `CLK_DIV` cycles; the receiver samples on this falling edge.
  - The data lanes stay stable through the full period.
- Outside SHIFT: `adc_clock` = 0 and the data lanes = 0. During DRDY, `adc_data_ready` = 1 and `adc_clock` = 0.
- Deasserting `enable` mid-frame: the frame completes, the GAP is honoured, then the FSM goes to IDLE.
- Asserting reset mid-frame: all outputs return to reset values immediately with no partial-frame completion. The register file also resets.
- Counters:
  - The bit counter is 9 bits and covers 0..255.
  - The divider counter is `$clog2(CLK_DIV)` bits.

## Timing
- Frame period with `enable` held high: `DRDY_WIDTH` + 512×`CLK_DIV` + `FRAME_GAP` cycles. With the defaults this is 4 + 2048 + 64 = 2116 cycles.
- First `adc_data_ready` high: the cycle after the first clock edge that samples `enable` = 1.
- First `adc_clock` rising edge: the cycle after `adc_data_ready` falls.
- `frame_done`: high during the first GAP cycle; this is `CLK_DIV` cycles after the 256th falling edge.
- `busy` rises with `adc_data_ready` and falls on entry to IDLE.

## Configuration
- `ADC_TX_PATTERN_EN` defined:
  - Adds the `pattern_sel` port and a 24-bit frame counter, which increments on `frame_done` and wraps from FFFFFF to 000000.
  - When `pattern_sel` = 1 at snapshot time, shadow word n is {5'b0, n[2:0], frame_count[23:0]} instead of the register file value.
- `ADC_TX_PATTERN_EN` undefined: no port, no counter; shadow words always come from the register file.

## Structure
- Shared package `adc_link_pkg`:
  - FSM state enum.
  - `ADC_NUM_CH` = 8, `ADC_WORD_W` = 32, `ADC_FRAME_BITS` = 256.
  - Reset word function (returns n for channel n).
- One sub-module `adc_bit_clock_gen`:
  - Function: `CLK_DIV` divider.
  - Outputs: `bit_start` and `bit_end` strobes plus `adc_clock`.
  - Control: gated by the SHIFT state.

## Test plan
- Reset, then `enable` = 1 with CLK_DIV = 4, no writes → lane 0 carries 32'h1 … 32'h8 MSB first and lane 1 carries the inverses. Frame period is exactly 2116 cycles; `frame_done` occurs once per frame.
- Write ch3 = 32'hA5A5_0F0F in the middle of SHIFT → the current frame still sends 32'h3 for ch3; the next frame sends A5A50F0F.
- Loopback into the receiver `adc_serial_interface` with `start` = 1 → `adc_channel_data_ch1..ch8` equal the written words after each frame.
- Drop `enable` at bit 100 → the frame completes all 256 bits, GAP lasts 64 cycles, then IDLE with `busy` = 0 and no further `adc_data_ready` pulse.
- Assert `reset` at bit 40 → all outputs are 0 in the same cycle, and after release the register file reads back the reset words.
- With `ADC_TX_PATTERN_EN` and `pattern_sel` = 1, run 3 frames → ch5 words are 04000000, 04000001, 04000002. Preload the counter to FFFFFF → the following frame shows 000000.

Source files
------------

// File: rtl/adc_link_pkg.sv
// Shared definitions for the ADC serial link: frame geometry, the transmitter
// FSM state type and the power-on contents of the channel register file.
package adc_link_pkg;

  localparam int ADC_NUM_CH     = 8;
  localparam int ADC_WORD_W     = 32;
  localparam int ADC_FRAME_BITS = ADC_NUM_CH * ADC_WORD_W;

  typedef logic [ADC_WORD_W-1:0] adc_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRDY  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } adc_tx_state_e;

  // Reset value of channel n (1-based channel number): the word n itself,
  // so an idle emulator still produces an easily recognisable frame.
  function automatic adc_word_t adc_reset_word(input int unsigned ch_num);
    return adc_word_t'(ch_num);
  endfunction

endpackage

// File: rtl/adc_bit_clock_gen.sv
// Serial bit clock generator. While shift_en is high it produces a square
// wave of CLK_DIV cycles high then CLK_DIV cycles low, starting high on the
// first enabled cycle. bit_start marks the first cycle of a bit period,
// bit_end the last. When shift_en is low the clock idles low and the divider
// is held in its start position so the next frame begins with a rising edge.
module adc_bit_clock_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic shift_en,
  output logic bit_start,
  output logic bit_end,
  output logic adc_clock
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             low_half_q;

  // Divider: counts CLK_DIV cycles per half period and flips the half.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      low_half_q <= 1'b0;
    end else if (!shift_en) begin
      div_q      <= '0;
      low_half_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q      <= '0;
      low_half_q <= ~low_half_q;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign adc_clock = shift_en & ~low_half_q;
  assign bit_start = shift_en & ~low_half_q & (div_q == '0);
  assign bit_end   = shift_en &  low_half_q & (div_q == DIV_LAST);

endmodule

// File: rtl/adc_frame_transmitter.sv
// On-board ADC emulator: emits a data-ready strobe, then 256 bits (8 channels
// x 32 bits, ch1 first, MSB first) on lane 0 with the inverse on lane 1,
// followed by an idle gap. Channel words come from a CPU-writable register
// file that is snapshotted into shadow words at each frame start, so writes
// never disturb the frame in flight.
// Optional feature: define ADC_TX_PATTERN_EN to add the pattern_sel port and
// a 24-bit frame counter that can replace the register file as word source.
module adc_frame_transmitter
  import adc_link_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DRDY_WIDTH = 4,
  parameter int FRAME_GAP  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        ch_wr_en,
  input  logic [2:0]  ch_wr_addr,
  input  logic [31:0] ch_wr_data,
`ifdef ADC_TX_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        adc_data_ready,
  output logic        adc_clock,
  output logic        adc_data_0,
  output logic        adc_data_1,
  output logic        busy,
  output logic        frame_done
);

  localparam int PHASE_MAX = (DRDY_WIDTH > FRAME_GAP) ? DRDY_WIDTH : FRAME_GAP;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam logic [PHASE_W-1:0] DRDY_LAST = PHASE_W'(DRDY_WIDTH - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(FRAME_GAP - 1);
  localparam logic [8:0]         LAST_BIT  = 9'(ADC_FRAME_BITS - 1);

  adc_tx_state_e      state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [8:0]         bit_cnt_q, bit_cnt_d;
  logic               snapshot;

  adc_word_t regfile_q [ADC_NUM_CH];
  adc_word_t shadow_q  [ADC_NUM_CH];
  adc_word_t snap_words[ADC_NUM_CH];

  logic in_shift;
  logic bit_start;
  logic bit_end;
  logic lane_bit;

  assign in_shift = (state_q == ST_SHIFT);

  adc_bit_clock_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_clock_gen (
    .clock     (clock),
    .reset     (reset),
    .shift_en  (in_shift),
    .bit_start (bit_start),
    .bit_end   (bit_end),
    .adc_clock (adc_clock)
  );

  // Frame sequencing: DRDY strobe, 256 bit periods, gap, then repeat or idle.
  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    snapshot  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_DRDY;
          phase_d  = '0;
          snapshot = 1'b1;
        end
      end
      ST_DRDY: begin
        if (phase_q == DRDY_LAST) begin
          state_d   = ST_SHIFT;
          phase_d   = '0;
          bit_cnt_d = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_SHIFT: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_GAP;
            phase_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 9'd1;
          end
        end
      end
      ST_GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          if (enable) begin
            state_d  = ST_DRDY;
            snapshot = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Channel register file: CPU writes land at any time, never stalled.
  // NOTE: this small array is reset explicitly because the emulator must
  // come up sending known words; large RAMs would normally not be reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ADC_NUM_CH; i++) begin
        regfile_q[i] <= adc_reset_word(32'(i + 1));
      end
    end else if (ch_wr_en) begin
      regfile_q[ch_wr_addr] <= ch_wr_data;
    end
  end

`ifdef ADC_TX_PATTERN_EN
  logic [23:0] frame_cnt_q;

  // Frame counter for the generated pattern, wrapping naturally at 24 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 24'd1;
    end
  end

  // Snapshot source: register file, or {channel index, frame count} pattern.
  always_comb begin
    for (int i = 0; i < ADC_NUM_CH; i++) begin
      snap_words[i] = regfile_q[i];
      if (pattern_sel) begin
        snap_words[i] = {5'b0, 3'(i), frame_cnt_q};
      end
    end
  end
`else
  // Snapshot source: always the register file.
  always_comb begin
    for (int i = 0; i < ADC_NUM_CH; i++) begin
      snap_words[i] = regfile_q[i];
    end
  end
`endif

  // Shadow words: captured on DRDY entry, so a same-cycle write (which only
  // reaches regfile_q after this edge) falls into the next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ADC_NUM_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (snapshot) begin
      shadow_q <= snap_words;
    end
  end

  // Bit k is bit 31-(k mod 32) of word k/32; the bit counter advances on
  // bit_end, so the lanes change together with the rising bit clock.
  assign lane_bit       = shadow_q[bit_cnt_q[7:5]][~bit_cnt_q[4:0]];
  assign adc_data_0     = in_shift &  lane_bit;
  assign adc_data_1     = in_shift & ~lane_bit;
  assign adc_data_ready = (state_q == ST_DRDY);
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = (state_q == ST_GAP) && (phase_q == '0);

  a_bit_start_in_frame: assert property (
    @(posedge clock) disable iff (reset) bit_start |-> (bit_cnt_q < 9'(ADC_FRAME_BITS))
  );

endmodule

// File: tb/tb_adc_frame_transmitter.sv
// Self-checking bench for adc_frame_transmitter (default build, default
// parameters). A frame-timeline model predicts every output each cycle from
// the time elapsed since frame start; bit-level monitors reassemble frames
// for literal checks of words, periods and control behaviour.
module tb_adc_frame_transmitter;

  localparam int CD        = 4;
  localparam int DW        = 4;
  localparam int FG        = 64;
  localparam int SHIFT_LEN = 512 * CD;
  localparam int FRAME_LEN = DW + SHIFT_LEN + FG;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        ch_wr_en;
  logic [2:0]  ch_wr_addr;
  logic [31:0] ch_wr_data;
  logic        adc_data_ready;
  logic        adc_clock;
  logic        adc_data_0;
  logic        adc_data_1;
  logic        busy;
  logic        frame_done;
  logic [5:0]  outs;

  adc_frame_transmitter #(
    .CLK_DIV    (CD),
    .DRDY_WIDTH (DW),
    .FRAME_GAP  (FG)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .ch_wr_en       (ch_wr_en),
    .ch_wr_addr     (ch_wr_addr),
    .ch_wr_data     (ch_wr_data),
    .adc_data_ready (adc_data_ready),
    .adc_clock      (adc_clock),
    .adc_data_0     (adc_data_0),
    .adc_data_1     (adc_data_1),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  assign outs = {adc_data_ready, adc_clock, adc_data_0, adc_data_1, busy, frame_done};

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // ---------------- behavioural model: time since frame start ----------------
  logic [31:0] m_regs[8];
  logic [31:0] m_snap[8];
  bit          m_active;
  int          m_t;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 32'(i + 1);
      m_snap[i] = '0;
    end
    m_active = 0;
    m_t      = 0;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      if (!m_active) begin
        if (enable) begin
          m_snap   = m_regs;
          m_active = 1;
          m_t      = 0;
        end
      end else begin
        m_t++;
        if (m_t == FRAME_LEN) begin
          if (enable) begin
            m_snap = m_regs;
            m_t    = 0;
          end else begin
            m_active = 0;
            m_t      = 0;
          end
        end
      end
      if (ch_wr_en) m_regs[ch_wr_addr] = ch_wr_data;
    end
  end

  // Expected {drdy, clk, d0, d1, busy, done} for the current model time.
  function automatic logic [5:0] model_out();
    logic [5:0] e;
    int s;
    int k;
    logic b;
    e = '0;
    if (m_active) begin
      e[1] = 1'b1;
      if (m_t < DW) begin
        e[5] = 1'b1;
      end else if (m_t < DW + SHIFT_LEN) begin
        s    = m_t - DW;
        k    = s / (2 * CD);
        b    = m_snap[k / 32][31 - (k % 32)];
        e[4] = ((s % (2 * CD)) < CD);
        e[3] = b;
        e[2] = ~b;
      end else if (m_t == DW + SHIFT_LEN) begin
        e[0] = 1'b1;
      end
    end
    return e;
  endfunction

  bit cmp_on = 0;

  always @(negedge clock) begin
    if (cmp_on && !reset) check($sformatf("outputs@cycle%0d", cyc), 64'(outs), 64'(model_out()));
  end

  // ---------------- monitors: reassemble frames as the receiver would ----------------
  logic [255:0] cap_sh = '0;
  int           cap_n  = 0;
  logic [255:0] frames[$];
  int           frame_bits[$];
  int           drdy_times[$];
  logic         prev_drdy = 1'b0;

  always @(negedge adc_clock) begin
    if (!reset) begin
      cap_sh = {cap_sh[254:0], adc_data_0};
      cap_n++;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      cap_n     = 0;
      prev_drdy = 1'b0;
    end else begin
      if (adc_data_ready && !prev_drdy) drdy_times.push_back(cyc);
      prev_drdy = adc_data_ready;
      if (frame_done) begin
        frames.push_back(cap_sh);
        frame_bits.push_back(cap_n);
        cap_n = 0;
      end
    end
  end

  function automatic logic [31:0] word_of(input logic [255:0] f, input int ch);
    return f[255 - 32 * ch -: 32];
  endfunction

  task automatic wait_frames(input int n, input int budget);
    int i;
    i = 0;
    while (frames.size() < n && i < budget) begin
      @(negedge clock);
      i++;
    end
    check($sformatf("frame%0d_arrival", n), 64'(frames.size() >= n), 64'd1);
  endtask

  task automatic wait_drdy_rise(input int budget);
    logic p;
    bit   found;
    found = 0;
    p     = adc_data_ready;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock);
      if (adc_data_ready && !p) found = 1;
      p = adc_data_ready;
    end
    check("drdy_rise_arrival", 64'(found), 64'd1);
  endtask

  task automatic write_ch(input logic [2:0] addr, input logic [31:0] data);
    ch_wr_en   = 1'b1;
    ch_wr_addr = addr;
    ch_wr_data = data;
    @(negedge clock);
    ch_wr_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    int   drdy_before;
    int   fbase;
    bit   found;

    reset      = 1'b1;
    enable     = 1'b0;
    ch_wr_en   = 1'b0;
    ch_wr_addr = '0;
    ch_wr_data = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 64'(outs), 64'd0);
    @(posedge clock);
    #2 reset = 1'b0;
    cmp_on = 1;
    repeat (5) @(negedge clock);
    check("idle_outputs", 64'(outs), 64'd0);

    // First frame: reset words, timing of the strobe and first bit clock.
    enable = 1'b1;
    @(negedge clock);
    check("first_drdy", 64'({adc_data_ready, busy, adc_clock}), 64'b110);
    repeat (DW) @(negedge clock);
    check("first_bit_clock", 64'({adc_data_ready, adc_clock}), 64'b01);
    wait_frames(1, FRAME_LEN + 100);
    if (frames.size() >= 1) begin
      for (int ch = 0; ch < 8; ch++)
        check($sformatf("f0_ch%0d", ch + 1), 64'(word_of(frames[0], ch)), 64'(ch + 1));
    end

    // Write ch3 mid-SHIFT of the second frame.
    repeat (FG + DW + 1000) @(negedge clock);
    write_ch(3'd2, 32'hA5A5_0F0F);
    wait_frames(3, 2 * FRAME_LEN + 100);
    check("frames_seen", 64'(frames.size()), 64'd3);
    check("drdy_seen", 64'(drdy_times.size()), 64'd3);
    if (frames.size() >= 3 && drdy_times.size() >= 3) begin
      check("f1_ch3_unchanged", 64'(word_of(frames[1], 2)), 64'h3);
      check("f2_ch3_written", 64'(word_of(frames[2], 2)), 64'hA5A5_0F0F);
      check("period_0_1", 64'(drdy_times[1] - drdy_times[0]), 64'd2116);
      check("period_1_2", 64'(drdy_times[2] - drdy_times[1]), 64'd2116);
      for (int f = 0; f < 3; f++)
        check($sformatf("f%0d_bitcount", f), 64'(frame_bits[f]), 64'd256);
    end

    // Random register writes while frames free-run.
    repeat (2 * FRAME_LEN) begin
      @(negedge clock);
      if ($urandom_range(0, 39) == 0) begin
        ch_wr_en   = 1'b1;
        ch_wr_addr = 3'($urandom_range(0, 7));
        ch_wr_data = $urandom;
      end else begin
        ch_wr_en = 1'b0;
      end
    end
    ch_wr_en = 1'b0;

    // Drop enable at bit 100: frame completes, full gap, then idle.
    wait_drdy_rise(FRAME_LEN + 100);
    repeat (DW + 2 * CD * 100) @(negedge clock);
    enable = 1'b0;
    found = 0;
    for (int i = 0; i < FRAME_LEN && !found; i++) begin
      @(negedge clock);
      if (frame_done) found = 1;
    end
    check("done_after_disable", 64'(found), 64'd1);
    n = 0;
    while (busy && n < FG + 10) begin
      @(negedge clock);
      n++;
    end
    check("gap_length", 64'(n), 64'd64);
    drdy_before = drdy_times.size();
    repeat (3000) @(negedge clock);
    check("idle_busy", 64'(busy), 64'd0);
    check("no_drdy_after_disable", 64'(drdy_times.size()), 64'(drdy_before));

    // Reset at bit 40: immediate zero outputs, register file back to reset words.
    write_ch(3'd2, 32'hDEAD_BEEF);
    enable = 1'b1;
    wait_drdy_rise(100);
    repeat (DW + 2 * CD * 40 + 1) @(negedge clock);
    check("busy_before_reset", 64'({busy, adc_clock}), 64'b11);
    @(posedge clock);
    #2 reset = 1'b1;
    enable = 1'b0;
    #1 check("reset_mid_frame", 64'(outs), 64'd0);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    fbase  = frames.size();
    wait_frames(fbase + 1, FRAME_LEN + 100);
    enable = 1'b0;
    if (frames.size() >= fbase + 1) begin
      for (int ch = 0; ch < 8; ch++)
        check($sformatf("post_reset_ch%0d", ch + 1), 64'(word_of(frames[fbase], ch)), 64'(ch + 1));
    end
    repeat (FG + 20) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
